// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer slice.
package piso_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer with full flag; load and unload are never asserted together.
module piso_hold_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with one-word hold buffer for gap-free frames.
// Optional even parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic             accept, data_end, frame_end;
  logic             shift_load, hold_load, hold_unload;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign din_ready  = !hold_full;
  assign accept     = din_valid & din_ready;
  assign data_end   = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
  assign frame_end  = (state == S_PAR);
`else
  assign frame_end  = data_end;
`endif
  assign sout_valid = (state != S_IDLE);
  assign sout_last  = frame_end;
  assign busy       = (state != S_IDLE) | hold_full;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .unload (hold_unload),
    .d      (din),
    .full   (hold_full),
    .q      (hold_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // At frame end the held word wins; a fresh accept loads the shifter only when hold is empty.
  always_comb begin
    state_nxt   = state;
    shift_load  = 1'b0;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    load_word   = din;
    case (state)
      S_IDLE: begin
        if (accept) begin
          shift_load = 1'b1;
          state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT, S_PAR: begin
        if (frame_end) begin
          if (hold_full) begin
            shift_load  = 1'b1;
            hold_unload = 1'b1;
            load_word   = hold_q;
            state_nxt   = S_SHIFT;
          end else if (accept) begin
            shift_load = 1'b1;
            state_nxt  = S_SHIFT;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          hold_load = accept;
`ifdef PISO_PARITY_EN
          if (data_end) state_nxt = S_PAR;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (shift_load) begin
      shreg <= load_word;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= ^load_word;
`endif
    end else if (state == S_SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
    end
  end

  always_comb begin
    sout = 1'b0;
    if (state == S_SHIFT) begin
      sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
`ifdef PISO_PARITY_EN
    else if (state == S_PAR) begin
      sout = par;
    end
`endif
  end

endmodule
